// File: rtl/idex_reg.sv
// ID/EX pipeline register with hold, load-use flush, and a saturating counter
// of bubbles entering the EX stage.
module idex_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flushIDEX,
  input  logic        hold,
  input  logic        IFIDvalid,
  input  logic        RegDst,
  input  logic        ALUSrc,
  input  logic        MemToReg,
  input  logic        RegWrite,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic        Branch,
  input  logic [3:0]  ALUOp,
  input  logic [31:0] PCplus4,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic [31:0] Imm32,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic        bubclr,
  output logic        IDEXvalid,
  output logic        IDEXRegDst,
  output logic        IDEXALUSrc,
  output logic        IDEXMemToReg,
  output logic        IDEXRegWrite,
  output logic        IDEXMemRd,
  output logic        IDEXMemWr,
  output logic        IDEXBranch,
  output logic [3:0]  IDEXALUOp,
  output logic [31:0] IDEXPCplus4,
  output logic [31:0] IDEXRsData,
  output logic [31:0] IDEXRtData,
  output logic [31:0] IDEXImm32,
  output logic [4:0]  IDEXRs,
  output logic [4:0]  IDEXRt,
  output logic [4:0]  IDEXRd,
  output logic [7:0]  bubcnt
);

  logic bubble;
  assign bubble = flushIDEX | ~IFIDvalid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      IDEXvalid    <= 1'b0;
      IDEXRegDst   <= 1'b0;
      IDEXALUSrc   <= 1'b0;
      IDEXMemToReg <= 1'b0;
      IDEXRegWrite <= 1'b0;
      IDEXMemRd    <= 1'b0;
      IDEXMemWr    <= 1'b0;
      IDEXBranch   <= 1'b0;
      IDEXALUOp    <= '0;
      IDEXPCplus4  <= '0;
      IDEXRsData   <= '0;
      IDEXRtData   <= '0;
      IDEXImm32    <= '0;
      IDEXRs       <= '0;
      IDEXRt       <= '0;
      IDEXRd       <= '0;
      bubcnt       <= '0;
    end else begin
      if (!hold) begin
        // Datapath values pass through even on a bubble; only control is squashed.
        IDEXPCplus4 <= PCplus4;
        IDEXRsData  <= RsData;
        IDEXRtData  <= RtData;
        IDEXImm32   <= Imm32;
        if (bubble) begin
          IDEXvalid    <= 1'b0;
          IDEXRegDst   <= 1'b0;
          IDEXALUSrc   <= 1'b0;
          IDEXMemToReg <= 1'b0;
          IDEXRegWrite <= 1'b0;
          IDEXMemRd    <= 1'b0;
          IDEXMemWr    <= 1'b0;
          IDEXBranch   <= 1'b0;
          IDEXALUOp    <= '0;
        end else begin
          IDEXvalid    <= 1'b1;
          IDEXRegDst   <= RegDst;
          IDEXALUSrc   <= ALUSrc;
          IDEXMemToReg <= MemToReg;
          IDEXRegWrite <= RegWrite;
          IDEXMemRd    <= MemRd;
          IDEXMemWr    <= MemWr;
          IDEXBranch   <= Branch;
          IDEXALUOp    <= ALUOp;
        end
        if (flushIDEX) begin
          IDEXRs <= '0;
          IDEXRt <= '0;
          IDEXRd <= '0;
        end else begin
          IDEXRs <= Rs;
          IDEXRt <= Rt;
          IDEXRd <= Rd;
        end
      end

      if (bubclr)
        bubcnt <= '0;
      else if (!hold && bubble && bubcnt != '1)
        bubcnt <= bubcnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_idex_reg.sv
// Directed self-checking bench for idex_reg.
module tb_idex_reg;

  logic        clk = 1'b0;
  logic        rst_n, flushIDEX, hold, IFIDvalid;
  logic        RegDst, ALUSrc, MemToReg, RegWrite, MemRd, MemWr, Branch;
  logic [3:0]  ALUOp;
  logic [31:0] PCplus4, RsData, RtData, Imm32;
  logic [4:0]  Rs, Rt, Rd;
  logic        bubclr;
  logic        IDEXvalid, IDEXRegDst, IDEXALUSrc, IDEXMemToReg, IDEXRegWrite;
  logic        IDEXMemRd, IDEXMemWr, IDEXBranch;
  logic [3:0]  IDEXALUOp;
  logic [31:0] IDEXPCplus4, IDEXRsData, IDEXRtData, IDEXImm32;
  logic [4:0]  IDEXRs, IDEXRt, IDEXRd;
  logic [7:0]  bubcnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  idex_reg dut (
    .clk(clk), .rst_n(rst_n), .flushIDEX(flushIDEX), .hold(hold),
    .IFIDvalid(IFIDvalid), .RegDst(RegDst), .ALUSrc(ALUSrc),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .MemRd(MemRd), .MemWr(MemWr),
    .Branch(Branch), .ALUOp(ALUOp), .PCplus4(PCplus4), .RsData(RsData),
    .RtData(RtData), .Imm32(Imm32), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .bubclr(bubclr),
    .IDEXvalid(IDEXvalid), .IDEXRegDst(IDEXRegDst), .IDEXALUSrc(IDEXALUSrc),
    .IDEXMemToReg(IDEXMemToReg), .IDEXRegWrite(IDEXRegWrite),
    .IDEXMemRd(IDEXMemRd), .IDEXMemWr(IDEXMemWr), .IDEXBranch(IDEXBranch),
    .IDEXALUOp(IDEXALUOp), .IDEXPCplus4(IDEXPCplus4),
    .IDEXRsData(IDEXRsData), .IDEXRtData(IDEXRtData), .IDEXImm32(IDEXImm32),
    .IDEXRs(IDEXRs), .IDEXRt(IDEXRt), .IDEXRd(IDEXRd), .bubcnt(bubcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flushIDEX = 0; hold = 0; IFIDvalid = 1; bubclr = 0;
    RegDst = 0; ALUSrc = 0; MemToReg = 0; RegWrite = 0;
    MemRd = 0; MemWr = 0; Branch = 0; ALUOp = 4'h0;
    PCplus4 = 32'h0; RsData = 32'h0; RtData = 32'h0; Imm32 = 32'h0;
    Rs = 5'd0; Rt = 5'd0; Rd = 5'd0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    RegWrite = 1; MemRd = 1; Rt = 5'd4; RtData = 32'h1234;
    step();
    chk("rst_valid", IDEXvalid, 0);
    chk("rst_regwrite", IDEXRegWrite, 0);
    chk("rst_memrd", IDEXMemRd, 0);
    chk("rst_rt", IDEXRt, 0);
    chk("rst_rtdata", IDEXRtData, 0);
    chk("rst_bubcnt", bubcnt, 0);

    // Normal load
    rst_n = 1; idle_inputs();
    MemRd = 1; Rt = 5'd9; RtData = 32'hDEADBEEF; RegDst = 1; RegWrite = 1;
    ALUOp = 4'hA; Rs = 5'd2; Rd = 5'd3; PCplus4 = 32'h104;
    step();
    chk("load_memrd", IDEXMemRd, 1);
    chk("load_rt", IDEXRt, 9);
    chk("load_rtdata", IDEXRtData, 32'hDEADBEEF);
    chk("load_valid", IDEXvalid, 1);
    chk("load_aluop", IDEXALUOp, 4'hA);
    chk("load_rd", IDEXRd, 3);
    chk("load_pc", IDEXPCplus4, 32'h104);
    chk("load_bubcnt", bubcnt, 0);

    // Flush
    idle_inputs();
    flushIDEX = 1; RegWrite = 1; MemWr = 1; MemRd = 1; ALUOp = 4'h5;
    Rt = 5'd9; Rd = 5'd6; Imm32 = 32'h10;
    step();
    chk("flush_regwrite", IDEXRegWrite, 0);
    chk("flush_memwr", IDEXMemWr, 0);
    chk("flush_memrd", IDEXMemRd, 0);
    chk("flush_aluop", IDEXALUOp, 0);
    chk("flush_rt", IDEXRt, 0);
    chk("flush_rd", IDEXRd, 0);
    chk("flush_imm", IDEXImm32, 32'h10);
    chk("flush_valid", IDEXvalid, 0);
    chk("flush_bubcnt", bubcnt, 1);

    // Load Rd=3, then hold with flush asserted for three edges
    idle_inputs();
    RegWrite = 1; Rd = 5'd3; Imm32 = 32'h77;
    step();
    chk("pre_hold_rd", IDEXRd, 3);
    flushIDEX = 1; hold = 1; RegWrite = 0; Rd = 5'd5; Imm32 = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_rd", IDEXRd, 3);
      chk("hold_regwrite", IDEXRegWrite, 1);
      chk("hold_valid", IDEXvalid, 1);
      chk("hold_imm", IDEXImm32, 32'h77);
      chk("hold_bubcnt", bubcnt, 1);
    end

    // Normal load of an invalid ID slot behaves as a bubble
    idle_inputs();
    IFIDvalid = 0; RegWrite = 1; MemRd = 1; ALUOp = 4'h3; PCplus4 = 32'h200;
    step();
    chk("inv_valid", IDEXvalid, 0);
    chk("inv_regwrite", IDEXRegWrite, 0);
    chk("inv_memrd", IDEXMemRd, 0);
    chk("inv_aluop", IDEXALUOp, 0);
    chk("inv_pc", IDEXPCplus4, 32'h200);
    chk("inv_bubcnt", bubcnt, 2);

    // 260 consecutive bubbles: 2 + 253 reaches 255, then saturates
    idle_inputs();
    flushIDEX = 1;
    for (int i = 0; i < 253; i++) step();
    chk("sat_reach", bubcnt, 255);
    for (int i = 0; i < 7; i++) step();
    chk("sat_hold", bubcnt, 255);

    bubclr = 1;
    step();
    chk("clr_vs_bubble", bubcnt, 0);
    bubclr = 0;
    step();
    chk("after_clr_inc", bubcnt, 1);
    hold = 1; bubclr = 1;
    step();
    chk("clr_under_hold", bubcnt, 0);
    bubclr = 0;
    step();
    chk("hold_freeze_cnt", bubcnt, 0);

    // Sync reset: between-edge pulse ignored, sampled low clears all
    idle_inputs();
    flushIDEX = 1;
    step();
    flushIDEX = 0; RegWrite = 1; MemWr = 1; Rd = 5'd12; RsData = 32'hCAFE;
    step();
    chk("preR_regwrite", IDEXRegWrite, 1);
    chk("preR_bubcnt", bubcnt, 1);
    hold = 1;
    #1 rst_n = 0;
    #3 rst_n = 1;
    step();
    chk("glitch_regwrite", IDEXRegWrite, 1);
    chk("glitch_rd", IDEXRd, 12);
    chk("glitch_bubcnt", bubcnt, 1);
    rst_n = 0;
    step();
    chk("midrst_regwrite", IDEXRegWrite, 0);
    chk("midrst_memwr", IDEXMemWr, 0);
    chk("midrst_valid", IDEXvalid, 0);
    chk("midrst_rd", IDEXRd, 0);
    chk("midrst_rsdata", IDEXRsData, 0);
    chk("midrst_bubcnt", bubcnt, 0);

    // Load-use pairing
    rst_n = 1; idle_inputs();
    MemRd = 1; Rt = 5'd7;
    step();
    chk("lu_memrd", IDEXMemRd, 1);
    chk("lu_rt", IDEXRt, 7);
    chk("lu_bubcnt", bubcnt, 0);
    flushIDEX = 1;
    step();
    chk("lu_flush_memrd", IDEXMemRd, 0);
    chk("lu_flush_bubcnt", bubcnt, 1);
    flushIDEX = 0; MemRd = 0; Rt = 5'd8;
    step();
    chk("lu_next_memrd", IDEXMemRd, 0);
    chk("lu_next_valid", IDEXvalid, 1);
    chk("lu_next_rt", IDEXRt, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idex_reg.md
IDEX_REG -- requirements
Module: idex_reg

Interface
REQ-001 The module SHALL have one clock and one reset; the reset SHALL be synchronous and active-low.
REQ-002 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 flushIDEX  input  1  load-use bubble request from hazard detection.
REQ-005 hold  input  1  downstream stall; freezes the whole register.
REQ-006 IFIDvalid  input  1  the ID-stage instruction is real (not a bubble).
REQ-007 RegDst, ALUSrc, MemToReg, RegWrite, MemRd, MemWr, Branch  input  1 each  decoded ID control.
REQ-008 ALUOp  input  4  decoded ALU operation.
REQ-009 PCplus4, RsData, RtData, Imm32  input  32 each  ID datapath values.
REQ-010 Rs, Rt, Rd  input  5 each  ID register specifiers.
REQ-011 IDEX-prefixed copies of every REQ-006..REQ-010 input (for example IDEXvalid, IDEXMemRd, IDEXRt)  output  same widths  registered EX-stage values.
REQ-012 bubclr  input  1  synchronous clear of the bubble counter.
REQ-013 bubcnt  output  8  saturating count of bubbles entering EX.

Function
REQ-014 All outputs SHALL be driven directly from flops, with no combinational path from input to output.
REQ-015 Per-edge update priority SHALL be: rst_n=0, then hold=1, then flushIDEX=1, then normal load.
REQ-016 Reset (rst_n=0) SHALL clear every IDEX output and bubcnt to 0.
REQ-017 hold=1 SHALL keep every IDEX output unchanged; flushIDEX SHALL be ignored on that edge.
REQ-018 Normal load (hold=0, flushIDEX=0) SHALL capture all inputs; latency is 1 cycle from ID input to IDEX output.
REQ-019 Flush (hold=0, flushIDEX=1) SHALL set IDEXvalid, all 1-bit controls, and ALUOp to 0.
REQ-020 Flush SHALL set IDEXRs, IDEXRt, and IDEXRd to 0.
REQ-021 Flush SHALL load PCplus4, RsData, RtData, and Imm32 normally.
REQ-022 After a flush edge, IDEXMemRd SHALL be 0, so a load-use hazard lasts at most one bubble.
REQ-023 A normal load with IFIDvalid=0 SHALL set IDEXvalid=0 and clear all 1-bit controls and ALUOp, exactly as a flush does.
REQ-024 A bubble event SHALL be an edge with hold=0 where either flushIDEX=1 or IFIDvalid=0.
REQ-025 bubcnt SHALL increment by 1 on each bubble event and saturate at 255; it SHALL never wrap to 0.
REQ-026 bubclr=1 SHALL set bubcnt to 0 and take precedence over a simultaneous bubble event.
REQ-027 bubclr SHALL act regardless of hold.
REQ-028 hold=1 SHALL freeze bubcnt unless bubclr=1.
REQ-029 Reset asserted mid-stream SHALL discard in-flight contents with no partial update.
REQ-030 The first edge after reset releases SHALL perform a normal priority evaluation.

Reset
REQ-031 Reset SHALL be sampled only on a rising clk edge; rst_n low between edges SHALL have no effect.
REQ-032 Once reset is sampled, IDEXvalid=0, IDEXRegWrite=0, IDEXMemRd=0, IDEXMemWr=0, IDEXBranch=0, and bubcnt=0 SHALL hold until the first non-reset edge.

Verification
REQ-033 Load: hold=0, flush=0, IFIDvalid=1, MemRd=1, Rt=5'd9, RtData=32'hDEADBEEF -> next cycle IDEXMemRd=1, IDEXRt=9, IDEXRtData=32'hDEADBEEF, IDEXvalid=1; bubcnt unchanged.
REQ-034 Flush: flushIDEX=1 with RegWrite=1, MemWr=1, Rt=5'd9, Imm32=32'h10 -> next cycle IDEXRegWrite=0, IDEXMemWr=0, IDEXRt=0, IDEXImm32=32'h10, IDEXvalid=0; bubcnt +1.
REQ-035 Hold vs flush: register holds IDEXRd=5'd3, then hold=1 with flushIDEX=1 for 3 cycles -> IDEXRd stays 3, controls unchanged, bubcnt unchanged.
REQ-036 Saturation and clear: 260 consecutive bubble events -> bubcnt=255; then bubclr=1 together with a bubble event -> bubcnt=0 next cycle.
REQ-037 Sync reset: rst_n pulsed low between edges only -> no change; rst_n=0 across an edge while loaded with RegWrite=1 -> all IDEX outputs 0 and bubcnt=0 on that edge.
REQ-038 Load-use pairing: load (MemRd=1, Rt=7) followed by a flush edge -> IDEXMemRd=0 on the following cycle, so the hazard input releases after exactly one bubble.
